// File: rtl/shifter_pkg.sv
// Shared constants and mode encodings for the 32-bit barrel shifter.
package shifter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = $clog2(DATA_W);

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  typedef enum logic {
    SHIFT_LOGICAL = 1'b0,
    SHIFT_ARITH   = 1'b1
  } shift_type_e;

endpackage

// File: rtl/shifter_stage.sv
// One stage of the log-shifter core: optionally shifts left by DIST, filling with fill_i.
module shifter_stage #(
  parameter int DATA_W = 32,
  parameter int DIST   = 1
) (
  input  logic              en_i,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] in_i,
  output logic [DATA_W-1:0] out_o
);

  assign out_o = en_i ? {in_i[DATA_W-DIST-1:0], {DIST{fill_i}}} : in_i;

endmodule

// File: rtl/shifter_32.sv
// 32-bit barrel shifter (left logical, right logical, right arithmetic) with a registered output.
module shifter_32
  import shifter_pkg::*;
#(
  parameter int DATA_W  = shifter_pkg::DATA_W,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic               shift_direction,
  input  logic               shift_type,
  output logic [DATA_W-1:0]  data_out
);

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  shift_dir_e        dir;
  shift_type_e       typ;
  logic              is_right;
  logic              fill;
  logic [DATA_W-1:0] core_in;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] stage_w [SHAMT_W+1];

  assign dir      = shift_dir_e'(shift_direction);
  assign typ      = shift_type_e'(shift_type);
  assign is_right = (dir == SHIFT_RIGHT);
  assign fill     = (typ == SHIFT_ARITH) & is_right & data_in[DATA_W-1];

  // Right shifts reuse the left-shift core by reversing the operand around it.
  assign core_in    = is_right ? bit_rev(data_in) : data_in;
  assign stage_w[0] = core_in;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shifter_stage #(
      .DATA_W(DATA_W),
      .DIST  (1 << k)
    ) u_stage (
      .en_i  (shift_amount[k]),
      .fill_i(fill),
      .in_i  (stage_w[k]),
      .out_o (stage_w[k+1])
    );
  end

  assign data_d = is_right ? bit_rev(stage_w[SHAMT_W]) : stage_w[SHAMT_W];

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_d;
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_shifter_32.sv
// Directed and swept checks of shifter_32 against hand-computed values and a shift model.
module tb_shifter_32;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  a;
    logic        dir;
    logic        typ;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [4:0]  shift_amount;
  logic        shift_direction;
  logic        shift_type;
  logic [31:0] data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shifter_32 dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .shift_amount   (shift_amount),
    .shift_direction(shift_direction),
    .shift_type     (shift_type),
    .data_out       (data_out)
  );

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a,
                                        input logic dir, input logic typ);
    logic signed [31:0] s;
    s = d;
    if (!dir)     return d << a;
    else if (typ) return $unsigned(s >>> a);
    else          return d >> a;
  endfunction

  task automatic apply(input logic [31:0] d, input logic [4:0] a, input logic dir, input logic typ);
    data_in         = d;
    shift_amount    = a;
    shift_direction = dir;
    shift_type      = typ;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(32'hDEADBEEF, 5'd3, 1'b0, 1'b0);
    apply(32'hDEADBEEF, 5'd3, 1'b0, 1'b0);
    total++;
    if (data_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got %08h want 00000000", data_out);
    end
    rst = 1'b0;
    apply(32'hDEADBEEF, 5'd4, 1'b0, 1'b0);
    total++;
    if (data_out !== 32'hEADBEEF0) begin
      bad++;
      $display("FAIL reset_release: got %08h want EADBEEF0", data_out);
    end
  endtask

  task automatic test_left();
    vec_t v[3];
    v[0] = '{32'hA5A5A5A5, 5'd4,  1'b0, 1'b0, 32'h5A5A5A50};
    v[1] = '{32'h00000001, 5'd31, 1'b0, 1'b0, 32'h80000000};
    v[2] = '{32'h00000001, 5'd31, 1'b0, 1'b1, 32'h80000000};
    foreach (v[i]) begin
      apply(v[i].d, v[i].a, v[i].dir, v[i].typ);
      total++;
      if (data_out !== v[i].exp) begin
        bad++;
        $display("FAIL left[%0d]: got %08h want %08h", i, data_out, v[i].exp);
      end
    end
  endtask

  task automatic test_right_logical();
    vec_t v[3];
    v[0] = '{32'hA5A5A5A5, 5'd8,  1'b1, 1'b0, 32'h00A5A5A5};
    v[1] = '{32'h80000000, 5'd31, 1'b1, 1'b0, 32'h00000001};
    v[2] = '{32'h7FFFFFFF, 5'd8,  1'b1, 1'b0, 32'h007FFFFF};
    foreach (v[i]) begin
      apply(v[i].d, v[i].a, v[i].dir, v[i].typ);
      total++;
      if (data_out !== v[i].exp) begin
        bad++;
        $display("FAIL right_logical[%0d]: got %08h want %08h", i, data_out, v[i].exp);
      end
    end
  endtask

  task automatic test_right_arith();
    vec_t v[5];
    v[0] = '{32'h7FFFFFFF, 5'd8,  1'b1, 1'b1, 32'h007FFFFF};
    v[1] = '{32'hF0000000, 5'd4,  1'b1, 1'b1, 32'hFF000000};
    v[2] = '{32'h80000000, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF};
    v[3] = '{32'hA5A5A5A5, 5'd1,  1'b1, 1'b1, 32'hD2D2D2D2};
    v[4] = '{32'h7FFFFFFF, 5'd31, 1'b1, 1'b1, 32'h00000000};
    foreach (v[i]) begin
      apply(v[i].d, v[i].a, v[i].dir, v[i].typ);
      total++;
      if (data_out !== v[i].exp) begin
        bad++;
        $display("FAIL right_arith[%0d]: got %08h want %08h", i, data_out, v[i].exp);
      end
    end
  endtask

  task automatic test_zero_amount();
    for (int m = 0; m < 4; m++) begin
      apply(32'h12345678, 5'd0, m[1], m[0]);
      total++;
      if (data_out !== 32'h12345678) begin
        bad++;
        $display("FAIL zero_amount[mode %0d]: got %08h want 12345678", m, data_out);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    apply(32'hF0000000, 5'd4, 1'b1, 1'b1);
    total++;
    if (data_out !== 32'h0) begin
      bad++;
      $display("FAIL midstream_reset: got %08h want 00000000", data_out);
    end
    rst = 1'b0;
    apply(32'hF0000000, 5'd4, 1'b1, 1'b1);
    total++;
    if (data_out !== 32'hFF000000) begin
      bad++;
      $display("FAIL midstream_release: got %08h want FF000000", data_out);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[4];
    v[0] = '{32'h0000FFFF, 5'd16, 1'b0, 1'b0, 32'hFFFF0000};
    v[1] = '{32'hFFFF0000, 5'd16, 1'b1, 1'b0, 32'h0000FFFF};
    v[2] = '{32'hFFFF0000, 5'd16, 1'b1, 1'b1, 32'hFFFFFFFF};
    v[3] = '{32'h00F00000, 5'd20, 1'b1, 1'b1, 32'h0000000F};
    foreach (v[i]) begin
      apply(v[i].d, v[i].a, v[i].dir, v[i].typ);
      total++;
      if (data_out !== v[i].exp) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %08h want %08h", i, data_out, v[i].exp);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    logic [31:0] exp;
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 32; a++) begin
        d   = $urandom;
        if (a[0]) d[31] = m[0];
        exp = model(d, a[4:0], m[1], m[0]);
        apply(d, a[4:0], m[1], m[0]);
        total++;
        if (data_out !== exp) begin
          bad++;
          $display("FAIL sweep[dir %0d type %0d amt %0d] in %08h: got %08h want %08h",
                   m[1], m[0], a, d, data_out, exp);
        end
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    data_in         = '0;
    shift_amount    = '0;
    shift_direction = 1'b0;
    shift_type      = 1'b0;
    test_reset();
    test_left();
    test_right_logical();
    test_right_arith();
    test_zero_amount();
    test_reset_midstream();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
